// File: rtl/music_pkg.sv
// Shared definitions for the score player: note half-period table, end marker, FSM states.
package music_pkg;

   localparam logic [7:0] END_MARKER = 8'hFF;

   // Row-major by octave (low, mid, high), then do..ti; values are round(1e6/(2f)) - 1
   localparam logic [0:20][11:0] NOTE_TABLE = {
      12'd3821, 12'd3404, 12'd3033, 12'd2863, 12'd2550, 12'd2272, 12'd2024,
      12'd1910, 12'd1702, 12'd1516, 12'd1431, 12'd1275, 12'd1135, 12'd1011,
      12'd955,  12'd850,  12'd757,  12'd715,  12'd637,  12'd567,  12'd505
   };

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      LOAD,
      TONE,
      GAP,
      FINISH
   } state_t;

endpackage

// File: rtl/note_decode.sv
// Combinational decode of one score byte into rest/end flags and a tone half-period.
module note_decode
   import music_pkg::*;
(
   input  logic [7:0]  note_byte,
   output logic        is_rest,
   output logic        is_end,
   output logic [11:0] half_period
);

   logic [3:0] octave;
   logic [3:0] note;
   logic [4:0] idx;

   assign octave = note_byte[7:4];
   assign note   = note_byte[3:0];

   // Anything outside octave 1..3 / note 1..7 falls through as a silent rest
   always_comb begin
      is_end      = (note_byte == END_MARKER);
      is_rest     = 1'b1;
      half_period = '0;
      idx         = '0;
      if (!is_end && octave >= 4'd1 && octave <= 4'd3 && note >= 4'd1 && note <= 4'd7) begin
         is_rest     = 1'b0;
         idx         = 5'(octave - 4'd1) * 5'd7 + 5'(note - 4'd1);
         half_period = NOTE_TABLE[idx];
      end
   end

endmodule

// File: rtl/music_score_player.sv
// Score sequencer: fetches one note byte per beat from a synchronous ROM and drives
// the tone generator's half-period word, with an articulation gap at the end of each slot.
module music_score_player
   import music_pkg::*;
#(
   parameter int unsigned BEAT_TICKS = 250000,
   parameter int unsigned GAP_TICKS  = 20000,
   parameter int unsigned ADDR_W     = 7,
   parameter bit          LOOP       = 1'b0
) (
   input  logic              clk_1M,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [11:0]       music_data,
   output logic              mute,
   output logic              playing,
   output logic              done
);

   localparam logic [31:0]       TONE_LAST = 32'(BEAT_TICKS - GAP_TICKS - 1);
   localparam logic [31:0]       GAP_LAST  = 32'(GAP_TICKS - 2);
   localparam logic [31:0]       FETCH_AT  = 32'(GAP_TICKS - 3);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t      state;
   logic [31:0] beat_cnt;
   logic        dec_rest;
   logic        dec_end;
   logic [11:0] dec_period;

   note_decode u_note_decode (
      .note_byte   (rom_data),
      .is_rest     (dec_rest),
      .is_end      (dec_end),
      .half_period (dec_period)
   );

   // The GAP state lasts GAP_TICKS-1 cycles; LOAD is the final muted cycle of the slot,
   // so the next address is issued early enough for the ROM's one-cycle latency.
   always_ff @(posedge clk_1M or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rom_addr   <= '0;
         music_data <= '0;
         mute       <= 1'b1;
         playing    <= 1'b0;
         done       <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state      <= IDLE;
            rom_addr   <= '0;
            music_data <= '0;
            mute       <= 1'b1;
            playing    <= 1'b0;
            beat_cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     rom_addr <= '0;
                     playing  <= 1'b1;
                     state    <= FETCH;
                  end
               end
               FETCH: state <= WAIT;
               WAIT:  state <= LOAD;
               LOAD: begin
                  if (dec_end) begin
                     state <= FINISH;
                  end else begin
                     music_data <= dec_rest ? 12'd0 : dec_period;
                     mute       <= dec_rest;
                     beat_cnt   <= '0;
                     state      <= TONE;
                  end
               end
               TONE: begin
                  if (beat_cnt >= TONE_LAST) begin
                     music_data <= '0;
                     mute       <= 1'b1;
                     beat_cnt   <= '0;
                     state      <= GAP;
                  end else begin
                     beat_cnt <= beat_cnt + 32'd1;
                  end
               end
               GAP: begin
                  if (beat_cnt >= GAP_LAST) begin
                     state <= LOAD;
                  end else begin
                     beat_cnt <= beat_cnt + 32'd1;
                  end
                  if (beat_cnt == FETCH_AT) begin
                     if (rom_addr == LAST_ADDR) begin
                        state <= FINISH;
                     end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                     end
                  end
               end
               FINISH: begin
                  rom_addr <= '0;
                  if (LOOP) begin
                     state <= FETCH;
                  end else begin
                     done    <= 1'b1;
                     playing <= 1'b0;
                     state   <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_music_score_player.sv
// Self-checking bench: a one-shot and a looping player share one score ROM image and are
// checked cycle by cycle against a slot-level model of the expected output trace.
`timescale 1ns/1ps
module tb_music_score_player;

   localparam int BEAT  = 20;
   localparam int GAP   = 4;
   localparam int AW    = 7;
   localparam int DEPTH = 128;

   logic          clk_1M = 1'b0;
   logic          rst_n;
   logic          start0, start1, stop;
   logic [AW-1:0] rom_addr0, rom_addr1;
   logic [7:0]    rom_data0, rom_data1;
   logic [11:0]   music0, music1;
   logic          mute0, mute1, playing0, playing1, done0, done1;

   logic [7:0] score [DEPTH];
   int PERIODS [21] = '{3821, 3404, 3033, 2863, 2550, 2272, 2024,
                        1910, 1702, 1516, 1431, 1275, 1135, 1011,
                        955,  850,  757,  715,  637,  567,  505};

   int exp_music[$];
   bit exp_mute[$];
   bit exp_play[$];
   bit exp_done[$];

   int total = 0;
   int bad   = 0;

   always #500 clk_1M = ~clk_1M;

   always @(posedge clk_1M) begin
      rom_data0 <= score[rom_addr0];
      rom_data1 <= score[rom_addr1];
   end

   music_score_player #(.BEAT_TICKS(BEAT), .GAP_TICKS(GAP), .ADDR_W(AW), .LOOP(1'b0)) dut_once (
      .clk_1M(clk_1M), .rst_n(rst_n), .start(start0), .stop(stop),
      .rom_addr(rom_addr0), .rom_data(rom_data0), .music_data(music0),
      .mute(mute0), .playing(playing0), .done(done0)
   );

   music_score_player #(.BEAT_TICKS(BEAT), .GAP_TICKS(GAP), .ADDR_W(AW), .LOOP(1'b1)) dut_loop (
      .clk_1M(clk_1M), .rst_n(rst_n), .start(start1), .stop(stop),
      .rom_addr(rom_addr1), .rom_data(rom_data1), .music_data(music1),
      .mute(mute1), .playing(playing1), .done(done1)
   );

   function automatic int expected_period(input logic [7:0] b);
      int oct;
      int nt;
      oct = int'(b[7:4]);
      nt  = int'(b[3:0]);
      if (oct < 1 || oct > 3 || nt < 1 || nt > 7) return 0;
      return PERIODS[(oct - 1) * 7 + nt - 1];
   endfunction

   task automatic push_cycles(input int n, input int m, input bit mu, input bit pl, input bit dn);
      repeat (n) begin
         exp_music.push_back(m);
         exp_mute.push_back(mu);
         exp_play.push_back(pl);
         exp_done.push_back(dn);
      end
   endtask

   // Expected per-cycle outputs from the cycle after start: three setup cycles, then one
   // BEAT-long slot per byte, then the end-of-score sequence (FINISH, then restart or done).
   task automatic build_expected(input bit loop, input int max_cycles);
      int         addr;
      int         p;
      bit         at_end;
      logic [7:0] b;
      exp_music.delete();
      exp_mute.delete();
      exp_play.delete();
      exp_done.delete();
      push_cycles(3, 0, 1'b1, 1'b1, 1'b0);
      addr = 0;
      while (exp_music.size() < max_cycles) begin
         b      = score[addr];
         at_end = 1'b0;
         if (b == 8'hFF) begin
            at_end = 1'b1;
         end else begin
            p = expected_period(b);
            push_cycles(BEAT - GAP, p, (p == 0), 1'b1, 1'b0);
            if (addr == DEPTH - 1) begin
               push_cycles(GAP - 2, 0, 1'b1, 1'b1, 1'b0);
               at_end = 1'b1;
            end else begin
               push_cycles(GAP, 0, 1'b1, 1'b1, 1'b0);
               addr++;
            end
         end
         if (at_end) begin
            push_cycles(1, 0, 1'b1, 1'b1, 1'b0);
            if (loop) begin
               push_cycles(3, 0, 1'b1, 1'b1, 1'b0);
               addr = 0;
            end else begin
               push_cycles(1, 0, 1'b1, 1'b0, 1'b1);
               push_cycles(max_cycles, 0, 1'b1, 1'b0, 1'b0);
            end
         end
      end
   endtask

   task automatic stop_all();
      @(negedge clk_1M);
      stop = 1'b1;
      @(negedge clk_1M);
      stop = 1'b0;
      @(negedge clk_1M);
   endtask

   // Starts the chosen player and compares every cycle; inject_at re-asserts start mid-play.
   task automatic run_trace(input bit loop, input int ncyc, input int inject_at, input string name);
      logic [14:0] obs;
      logic [14:0] want;
      int          fails;
      fails = 0;
      build_expected(loop, ncyc);
      @(negedge clk_1M);
      if (loop) start1 = 1'b1; else start0 = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk_1M);
         start0 = 1'b0;
         start1 = 1'b0;
         if (c == inject_at) begin
            if (loop) start1 = 1'b1; else start0 = 1'b1;
         end
         obs  = loop ? {music1, mute1, playing1, done1} : {music0, mute0, playing0, done0};
         want = {12'(exp_music[c-1]), exp_mute[c-1], exp_play[c-1], exp_done[c-1]};
         total++;
         if (obs !== want) begin
            bad++;
            fails++;
            $display("[TB] FAIL %s cycle %0d: got music=%0d mute=%b playing=%b done=%b, want music=%0d mute=%b playing=%b done=%b",
                     name, c, obs[14:3], obs[2], obs[1], obs[0], want[14:3], want[2], want[1], want[0]);
         end
         if (fails >= 5) break;
      end
      stop_all();
   endtask

   task automatic load_score(input logic [7:0] bytes[$]);
      for (int i = 0; i < DEPTH; i++) score[i] = 8'hFF;
      for (int i = 0; i < bytes.size(); i++) score[i] = bytes[i];
   endtask

   function automatic logic [7:0] random_byte();
      int         kind;
      logic [7:0] b;
      kind = $urandom_range(0, 3);
      case (kind)
         0, 2:    b = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 7))};
         1:       b = 8'($urandom_range(0, 254));
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   task automatic test_reset();
      logic [AW+15:0] obs;
      rst_n = 1'b0;
      repeat (3) @(negedge clk_1M);
      obs = {rom_addr0, music0, mute0, playing0, done0};
      total++;
      if (obs !== {7'd0, 12'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL reset_values: got addr=%0d music=%0d mute=%b playing=%b done=%b, want 0/0/1/0/0",
                  rom_addr0, music0, mute0, playing0, done0);
      end
      rst_n = 1'b1;
      @(negedge clk_1M);
      load_score('{8'h23, 8'h24, 8'h25, 8'hFF});
      start0 = 1'b1;
      @(negedge clk_1M);
      start0 = 1'b0;
      repeat (30) @(negedge clk_1M);
      #200 rst_n = 1'b0;
      #1;
      total++;
      if ({rom_addr0, music0, mute0, playing0} !== {7'd0, 12'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL async_reset: got addr=%0d music=%0d mute=%b playing=%b, want 0/0/1/0",
                  rom_addr0, music0, mute0, playing0);
      end
      @(negedge clk_1M);
      rst_n = 1'b1;
      @(negedge clk_1M);
   endtask

   task automatic test_basic_score();
      load_score('{8'h23, 8'h24, 8'h25, 8'hFF});
      run_trace(1'b0, 3 + 3 * BEAT + 8, 0, "basic_score");
   endtask

   task automatic test_rest_score();
      load_score('{8'h00, 8'h31, 8'hFF});
      run_trace(1'b0, 3 + 2 * BEAT + 8, 0, "rest_score");
   endtask

   task automatic test_loop();
      load_score('{8'h23, 8'h24, 8'h25, 8'hFF});
      run_trace(1'b1, 3 + 3 * (3 * BEAT + 4), 0, "loop_restart");
   endtask

   task automatic test_stop();
      int dones;
      load_score('{8'h23, 8'h24, 8'h25, 8'hFF});
      @(negedge clk_1M);
      start0 = 1'b1;
      repeat (29) begin
         @(negedge clk_1M);
         start0 = 1'b0;
      end
      total++;
      if (music0 !== 12'd1431) begin
         bad++;
         $display("[TB] FAIL stop_setup_note2: got music=%0d, want 1431", music0);
      end
      stop = 1'b1;
      @(negedge clk_1M);
      stop = 1'b0;
      total++;
      if ({music0, mute0, playing0, rom_addr0} !== {12'd0, 1'b1, 1'b0, 7'd0}) begin
         bad++;
         $display("[TB] FAIL stop_response: got music=%0d mute=%b playing=%b addr=%0d, want 0/1/0/0",
                  music0, mute0, playing0, rom_addr0);
      end
      dones = 0;
      repeat (80) begin
         @(negedge clk_1M);
         if (done0 === 1'b1 || playing0 !== 1'b0) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("[TB] FAIL stop_quiet: got %0d cycles with done/playing, want 0", dones);
      end
   endtask

   task automatic test_start_stop_together();
      int active;
      @(negedge clk_1M);
      start0 = 1'b1;
      stop   = 1'b1;
      @(negedge clk_1M);
      start0 = 1'b0;
      stop   = 1'b0;
      active = 0;
      repeat (5) begin
         if (playing0 !== 1'b0 || music0 !== 12'd0) active++;
         @(negedge clk_1M);
      end
      total++;
      if (active != 0) begin
         bad++;
         $display("[TB] FAIL start_stop_together: got %0d active cycles, want 0", active);
      end
   endtask

   task automatic test_start_during_tone();
      load_score('{8'h23, 8'h24, 8'h25, 8'hFF});
      run_trace(1'b0, 3 + 3 * BEAT + 8, 10, "start_during_tone");
   endtask

   task automatic test_random_scores();
      logic [7:0] bytes[$];
      int         len;
      for (int it = 0; it < 6; it++) begin
         bytes.delete();
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) bytes.push_back(random_byte());
         bytes.push_back(8'hFF);
         load_score(bytes);
         if (it % 2 == 0)
            run_trace(1'b0, 3 + len * BEAT + 8, 0, "random_once");
         else
            run_trace(1'b1, 3 + 2 * (len * BEAT + 4) + BEAT, 0, "random_loop");
      end
   endtask

   task automatic test_wrap();
      score[0] = 8'h48;
      for (int i = 1; i < DEPTH; i++)
         score[i] = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 7))};
      run_trace(1'b0, 3 + DEPTH * BEAT + 8, 0, "address_wrap");
   endtask

   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      stop   = 1'b0;
      for (int i = 0; i < DEPTH; i++) score[i] = 8'hFF;
      test_reset();
      test_basic_score();
      test_rest_score();
      test_loop();
      test_stop();
      test_start_stop_together();
      test_start_during_tone();
      test_random_scores();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
